// File: rtl/pool_ctrl.sv
// pool_ctrl: valid/ready sequencer around the 2x2/stride-2 max-pool datapath.
// Loads a 6x6x3 byte frame, hands it to the combinational pool datapath and
// streams the 27 pooled bytes out.
// Optional feature macro: POOL_CTRL_OVERLAP_EN -- when defined, the output drain
// runs alongside loading of the next frame instead of blocking it.
module pool_ctrl #(
  parameter int unsigned DW    = 8,
  parameter int unsigned IN_N  = 108,
  parameter int unsigned OUT_N = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_last,
  output logic [IN_N*DW-1:0]    conv_lin,
  input  logic [OUT_N*DW-1:0]   pool_lin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic                  frame_done,
  output logic                  len_err
);

  localparam int unsigned IW = $clog2(IN_N);
  localparam int unsigned OW = $clog2(OUT_N);
  localparam logic [IW-1:0] IN_LAST  = IW'(IN_N - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(OUT_N - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_POOL = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                  state;
  logic [IW-1:0]           in_cnt;
  logic [OW-1:0]           out_cnt;
  logic [OUT_N*DW-1:0]     out_buf;

  logic in_fire;
  logic out_fire;
  logic out_last_fire;

  // Handshake qualifiers
  assign in_fire       = in_valid & in_ready;
  assign out_fire      = out_valid & out_ready;
  assign out_last_fire = out_fire && (out_cnt == OUT_LAST);

  // Load / pool / drain sequencer with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOAD;
      in_cnt     <= '0;
      out_cnt    <= '0;
      conv_lin   <= '0;
      out_buf    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      len_err    <= 1'b0;

`ifdef POOL_CTRL_OVERLAP_EN
      // Independent drain of the captured result
      if (out_fire) begin
        if (out_cnt == OUT_LAST) begin
          out_valid  <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          out_cnt  <= out_cnt + OW'(1);
          out_data <= out_buf[(int'(out_cnt) + 1) * int'(DW) +: DW];
        end
      end
`endif

      case (state)
        S_LOAD: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            conv_lin[int'(in_cnt) * int'(DW) +: DW] <= in_data;
            if ((in_cnt == IN_LAST) || in_last) begin
              in_cnt <= '0;
              if ((in_cnt == IN_LAST) && in_last) begin
                state    <= S_POOL;
                in_ready <= 1'b0;
              end else begin
                len_err  <= 1'b1;
              end
            end else begin
              in_cnt <= in_cnt + IW'(1);
            end
          end
        end

        S_POOL: begin
`ifdef POOL_CTRL_OVERLAP_EN
          // Capture only once the previous result has fully left (or leaves now)
          if (!out_valid || out_last_fire) begin
            out_buf   <= pool_lin;
            out_data  <= pool_lin[DW-1:0];
            out_cnt   <= '0;
            out_valid <= 1'b1;
            state     <= S_LOAD;
            in_ready  <= 1'b1;
          end
`else
          out_buf   <= pool_lin;
          out_data  <= pool_lin[DW-1:0];
          out_cnt   <= '0;
          out_valid <= 1'b1;
          state     <= S_OUT;
`endif
        end

        S_OUT: begin
`ifdef POOL_CTRL_OVERLAP_EN
          state <= S_LOAD;
`else
          if (out_fire) begin
            if (out_cnt == OUT_LAST) begin
              out_valid  <= 1'b0;
              frame_done <= 1'b1;
              state      <= S_LOAD;
              in_ready   <= 1'b1;
            end else begin
              out_cnt  <= out_cnt + OW'(1);
              out_data <= out_buf[(int'(out_cnt) + 1) * int'(DW) +: DW];
            end
          end
`endif
        end

        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_ctrl.sv
// tb_pool_ctrl: directed + randomized checks of pool_ctrl against a frame-level
// max-pool reference model. The bench also plays the combinational pool datapath.
module tb_pool_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned IN_N  = 108;
  localparam int unsigned OUT_N = 27;

  typedef logic [7:0] frame_t [IN_N];
  typedef logic [7:0] res_t [OUT_N];

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_data;
  logic                 in_last;
  logic [IN_N*DW-1:0]   conv_lin;
  logic [OUT_N*DW-1:0]  pool_lin;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic                 frame_done;
  logic                 len_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pool_ctrl #(.DW(DW), .IN_N(IN_N), .OUT_N(OUT_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .conv_lin(conv_lin), .pool_lin(pool_lin),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .frame_done(frame_done), .len_err(len_err)
  );

  // Environment: combinational max-pool datapath on the flat frame bus
  function automatic logic [OUT_N*DW-1:0] datapath(input logic [IN_N*DW-1:0] lin);
    logic [OUT_N*DW-1:0] o;
    o = '0;
    for (int k = 0; k < 27; k++) begin
      int base;
      logic [7:0] a, b, c, e, m;
      base = (k / 9) * 36 + ((k % 9) / 3) * 12 + (k % 3) * 2;
      a = lin[base * 8 +: 8];
      b = lin[(base + 1) * 8 +: 8];
      c = lin[(base + 6) * 8 +: 8];
      e = lin[(base + 7) * 8 +: 8];
      m = (a > b) ? a : b;
      m = (c > m) ? c : m;
      m = (e > m) ? e : m;
      o[k * 8 +: 8] = m;
    end
    return o;
  endfunction

  assign pool_lin = datapath(conv_lin);

  // Reference: 2x2 max over each window of the frame as sent
  function automatic res_t ref_pool(input frame_t f);
    res_t r;
    for (int d = 0; d < 3; d++)
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 3; x++) begin
          int best;
          best = 0;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
              if (int'(f[d*36 + (2*y+dy)*6 + 2*x+dx]) > best)
                best = int'(f[d*36 + (2*y+dy)*6 + 2*x+dx]);
          r[d*9 + y*3 + x] = 8'(best);
        end
    return r;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < 108; i++) f[i] = 8'($urandom);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream n bytes of f; in_last on byte last_at (-1: never). Returns at the
  // negedge after the final handshake; cycles = negedges spent presenting bytes.
  task automatic send(input frame_t f, input int n, input int last_at, output int cycles);
    int w;
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = f[i];
      in_last  = (i == last_at);
      cycles++;
      w = 0;
      while (!in_ready && w < 500) begin
        @(negedge clk);
        w++;
        cycles++;
      end
      if (!in_ready) begin
        chk("send_timeout", 64'(w), 64'(0));
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Collect 27 bytes. mode 0: always ready, 1: toggle, 2: random.
  // After the final handshake checks frame_done and whether out_valid stays up.
  task automatic recv(input string tag, input res_t exp, input int mode, input logic next_valid);
    int k;
    int cyc;
    logic tog;
    logic rdy;
    logic stalled;
    logic [7:0] held;
    k = 0; cyc = 0; tog = 1'b0; stalled = 1'b0; held = '0;
    while (k < 27 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_hold_data"}, 64'(out_data), 64'(held));
      end
      tog = ~tog;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = tog;
        default: rdy = 1'($urandom);
      endcase
      out_ready = rdy;
      stalled = 1'b0;
      if (out_valid) begin
        if (rdy) begin
          chk($sformatf("%s_byte%0d", tag, k), 64'(out_data), 64'(exp[k]));
          k++;
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end
    end
    if (k < 27) begin
      chk({tag, "_recv_timeout"}, 64'(k), 64'(27));
    end else begin
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_frame_done"}, 64'(frame_done), 64'(1));
      chk({tag, "_after_valid"}, 64'(out_valid), 64'(next_valid));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(frame_done), 64'(0));
    end
  endtask

  // Watchdog
  initial begin
    #1ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t fa, fb;
    res_t   ea, eb, e1;
    int     cyc;
    logic   ovl;
`ifdef POOL_CTRL_OVERLAP_EN
    ovl = 1'b1;
`else
    ovl = 1'b0;
`endif
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_len_err", 64'(len_err), 64'(0));
    chk("rst_conv_lin", 64'(|conv_lin), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // T1: ramp frame, constant expected values, latency of 2 cycles
    for (int i = 0; i < 108; i++) fa[i] = 8'(i);
    for (int k = 0; k < 27; k++)
      e1[k] = 8'((k/9)*36 + (2*((k%9)/3)+1)*6 + 2*(k%3) + 1);
    send(fa, 108, 107, cyc);
    chk("t1_in_cycles", 64'(cyc), 64'(108));
    chk("t1_lat_t1_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("t1_lat_t2_valid", 64'(out_valid), 64'(1));
    chk("t1_lat_t2_data", 64'(out_data), 64'(7));
    chk("t1_in_ready_drain", 64'(in_ready), 64'(ovl));
    recv("t1", e1, 0, 1'b0);

    // T2: same frame, out_ready toggling
    send(fa, 108, 107, cyc);
    recv("t2", e1, 1, 1'b0);

    // T3: early in_last on byte 50, then a random frame
    fa = rand_frame();
    send(fa, 51, 50, cyc);
    chk("t3_len_err", 64'(len_err), 64'(1));
    chk("t3_no_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("t3_len_err_pulse", 64'(len_err), 64'(0));
    chk("t3_no_valid2", 64'(out_valid), 64'(0));
    fa = rand_frame();
    ea = ref_pool(fa);
    send(fa, 108, 107, cyc);
    recv("t3", ea, 2, 1'b0);

    // T4: 108 bytes without in_last, then all-0xFF frame
    fa = rand_frame();
    send(fa, 108, -1, cyc);
    chk("t4_len_err", 64'(len_err), 64'(1));
    @(negedge clk);
    chk("t4_no_valid", 64'(out_valid), 64'(0));
    for (int i = 0; i < 108; i++) fa[i] = 8'hFF;
    for (int k = 0; k < 27; k++) ea[k] = 8'hFF;
    send(fa, 108, 107, cyc);
    recv("t4", ea, 0, 1'b0);

    // T5: reset in the middle of a frame
    fa = rand_frame();
    send(fa, 60, -1, cyc);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_in_ready", 64'(in_ready), 64'(0));
    chk("t5_rst_out_valid", 64'(out_valid), 64'(0));
    chk("t5_rst_conv_lin", 64'(|conv_lin), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_in_ready", 64'(in_ready), 64'(1));
    chk("t5_out_valid", 64'(out_valid), 64'(0));
    fa = rand_frame();
    ea = ref_pool(fa);
    send(fa, 108, 107, cyc);
    recv("t5", ea, 2, 1'b0);

    // Randomized frames with random backpressure
    for (int n = 0; n < 3; n++) begin
      fa = rand_frame();
      ea = ref_pool(fa);
      send(fa, 108, 107, cyc);
      recv($sformatf("rnd%0d", n), ea, 2, 1'b0);
    end

`ifdef POOL_CTRL_OVERLAP_EN
    // T6: frame B loads while frame A waits to drain; B follows A back-to-back
    fa = rand_frame();
    fb = rand_frame();
    ea = ref_pool(fa);
    eb = ref_pool(fb);
    send(fa, 108, 107, cyc);
    @(negedge clk);
    chk("t6_a_valid", 64'(out_valid), 64'(1));
    chk("t6_a_byte0", 64'(out_data), 64'(ea[0]));
    send(fb, 108, 107, cyc);
    chk("t6_b_in_cycles", 64'(cyc), 64'(108));
    @(negedge clk);
    chk("t6_pool_wait_ready", 64'(in_ready), 64'(0));
    recv("t6a", ea, 0, 1'b1);
    recv("t6b", eb, 1, 1'b0);
`else
    fb = fa;
    eb = ea;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
